fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised instruction-fetch stage with a small prefetch buffer, PC redirect and downstream back-pressure. It generates word-aligned PCs, issues requests to a synchronous instruction memory with one-cycle read latency, and queues returned instructions with their PCs in a FIFO. It sits between the instruction memory and decode: decode pops `{pc, inst}` pairs via valid/ready, and execute redirects fetch on taken branches and jumps.

## Interface
- `XLEN`, 32: PC and instruction width.
- `IMEM_AW`, 6: instruction-memory word-address width.
- `RESET_PC`, 0: PC fetched first after reset. Bits [1:0] must be 0.
- `BUF_DEPTH`, 2: prefetch FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk` in 1: clock. All state changes on the posedge only.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out IMEM_AW: word address, equal to `fpc[IMEM_AW+1:2]`.
- `imem_rdata` in XLEN: read data. Valid the cycle after a request is sampled.
- `redirect_valid` in 1: restart fetch at `redirect_pc`.
- `redirect_pc` in XLEN: new PC. Bits [1:0] are ignored and treated as 0.
- `inst_valid` out 1: FIFO head is valid.
- `inst_ready` in 1: decode accepts the head.
- `inst_pc` out XLEN: PC of the head entry.
- `inst_code` out XLEN: instruction of the head entry.

## Operation
- **State:** fetch PC `fpc`, FIFO (`count`, read/write pointers, entries `{pc, inst}`), `inflight` flag, `inflight_pc` register.
- **Pop:** `pop = inst_valid & inst_ready & ~redirect_valid`.
- **Request credit:** `imem_req = ~reset & ~redirect_valid & (count + inflight - pop < BUF_DEPTH)`. This is combinational and keeps full throughput while decode pops every cycle.
- **On request (posedge):**
  - `inflight_pc <= fpc`
  - `fpc <= fpc + 4` (wraps modulo 2^XLEN)
  - `inflight <= 1`
- **No request:** `inflight <= 0`.
- **Response:** when `inflight` is 1, `{inflight_pc, imem_rdata}` is written at the FIFO tail on that posedge.
  - Push and pop in the same cycle leave `count` unchanged.
  - Credit guarantees the FIFO never overflows. Push-when-full is a design error; the bench asserts on it.
- **Redirect** (highest priority), at the posedge:
  - `fpc <= {redirect_pc[XLEN-1:2], 2'b00}`
  - FIFO flushed: `count <= 0`, pointers reset.
  - `inflight <= 0`, so any response returning this cycle is dropped.
  - No request is issued in the redirect cycle.
- **Outputs:** `inst_valid = (count != 0)`. `inst_pc`/`inst_code` show the head slot and are meaningful only while `inst_valid` is high.
- **Address range:** `imem_addr` truncates `fpc`. PCs beyond 4·2^IMEM_AW alias in memory, but `inst_pc` carries the full XLEN PC.

## Timing
- **Reset values:**
  - `fpc = RESET_PC`, `count = 0`, `inflight = 0`.
  - `imem_req = 0` while `reset` is high; `imem_addr` follows `fpc`, so it is `RESET_PC[IMEM_AW+1:2]`.
  - `inst_valid = 0`, `inst_pc = 0`, `inst_code = 0` (all FIFO entries cleared).
- **Reset mid-operation:** all state returns to reset values immediately, without waiting for a clock edge. An outstanding memory response is ignored.
- **First fetch:** in cycle 0 (reset low), `imem_req = 1` with address `RESET_PC>>2`. Memory samples at posedge E1, data is pushed at E2, and `inst_valid` is high after E2. Fetch-to-valid latency is 2 edges.
- **Steady state:** with `inst_ready` held at 1, one instruction is delivered per cycle with consecutive PCs. There are no bubbles after the first.
- **Back-pressure:** with `inst_ready = 0`, fetch stops once `count + inflight = BUF_DEPTH`. `inst_valid`, `inst_pc` and `inst_code` then hold stable.
- **Redirect latency:** for a redirect asserted in cycle t, the request for the new PC goes out in t+1 and `inst_valid` is high after the posedge ending t+2. `inst_valid` is 0 in t+1 and t+2.
- **Simultaneous events:**
  - Redirect with a response: the response is dropped.
  - Redirect with `inst_ready`: no pop is counted; the whole FIFO is discarded.
  - Push and pop together: `count` is unchanged.

## Test plan
- **Reset and start-up:** `RESET_PC = 0`, reset released, ROM word k = 0x1000+k, `inst_ready = 1`. Expect `inst_valid` high after the 2nd edge, then `inst_pc` = 0, 4, 8, … with `inst_code` = 0x1000, 0x1001, 0x1002, … on consecutive cycles.
- **Back-pressure:** hold `inst_ready = 0` for 6 cycles mid-stream. Expect `imem_req` low once 2 entries are outstanding, the head frozen, and on release the sequence resumes with no skipped or duplicated PC.
- **Redirect:** `redirect_valid` with `redirect_pc = 0x40` while the FIFO is full and a response is in flight. Expect `inst_valid` low for 2 cycles, then `inst_pc` = 0x40, 0x44, … with no stale entries.
- **Redirect edge cases:**
  - `redirect_pc = 0x43` fetches 0x40.
  - `redirect_pc = 0xFC` with `IMEM_AW = 6` gives `imem_addr` = 63, and the next `inst_pc` is 0x100 with `imem_addr` = 0.
- **Async reset mid-stream:** assert `reset` between clock edges while 2 entries are queued. Expect `inst_valid` and `imem_req` to drop immediately, then restart from `RESET_PC` with 2-edge latency.
- **Parameter sweep:** `BUF_DEPTH = 4`, `XLEN = 32`, random `inst_ready` over 2000 cycles. Scoreboard the PC/instruction order and check that the FIFO never overflows.

Source files
------------

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction fetch stage with prefetch FIFO, redirect and back-pressure
module fetch_prefetch #(
    parameter int              XLEN      = 32,
    parameter int              IMEM_AW   = 6,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst_pc,
    output logic [XLEN-1:0]    inst_code
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_q   [BUF_DEPTH];
    logic [XLEN-1:0] inst_q [BUF_DEPTH];
    logic            pop;
    logic [CW:0]     credit;

    assign inst_valid = (count != '0);
    assign inst_pc    = pc_q[rd_ptr];
    assign inst_code  = inst_q[rd_ptr];
    assign imem_addr  = fpc[IMEM_AW+1:2];

    // A redirect discards the whole FIFO, so a concurrent handshake is not a pop.
    assign pop = inst_valid & inst_ready & ~redirect_valid;

    // Occupancy after this edge if we issue now; the in-flight word already owns a slot.
    assign credit   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req = ~reset & ~redirect_valid & (credit < DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc         <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_req) begin
                inflight_pc <= fpc;
                fpc         <= fpc + XLEN'(4);
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (inflight) begin
                pc_q[wr_ptr]   <= inflight_pc;
                inst_q[wr_ptr] <= imem_rdata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed and randomised checks of fetch_prefetch
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_code;

    logic        reset4;
    logic        imem_req4;
    logic [5:0]  imem_addr4;
    logic [31:0] imem_rdata4 = '0;
    logic        inst_valid4;
    logic        ready4;
    logic [31:0] inst_pc4;
    logic [31:0] inst_code4;

    int errors = 0;
    int checks = 0;
    logic [31:0] nxt;

    always #5 clk = ~clk;

    fetch_prefetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_code(inst_code)
    );

    fetch_prefetch #(.BUF_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset4), .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_rdata(imem_rdata4), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(inst_valid4), .inst_ready(ready4), .inst_pc(inst_pc4), .inst_code(inst_code4)
    );

    // ROM word k holds 0x1000 + k, one-cycle read latency
    always @(posedge clk) if (imem_req)  imem_rdata  <= 32'h1000 + {26'd0, imem_addr};
    always @(posedge clk) if (imem_req4) imem_rdata4 <= 32'h1000 + {26'd0, imem_addr4};

    function automatic logic [31:0] code_of(input logic [31:0] pc);
        return 32'h1000 + {26'd0, pc[7:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("strm_valid", 32'(inst_valid), 32'd1);
            check("strm_pc", inst_pc, nxt);
            check("strm_code", inst_code, code_of(nxt));
            nxt = nxt + 32'd4;
            next_cyc();
        end
    endtask

    task automatic startup;
        drive(1'b1, 1'b0, 32'h0);
        check("s0_req", 32'(imem_req), 32'd1);
        check("s0_addr", 32'(imem_addr), 32'd0);
        check("s0_valid", 32'(inst_valid), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0);
        check("s1_valid", 32'(inst_valid), 32'd0);
        next_cyc();
        nxt = 32'h0;
        stream(6);
    endtask

    task automatic redir(input logic [31:0] rpc, input logic [31:0] exp_pc, input logic [5:0] exp_addr);
        logic [5:0] a1;
        a1 = exp_addr + 6'd1;
        drive(1'b1, 1'b1, rpc);
        check("rd0_req", 32'(imem_req), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0);
        check("rd1_valid", 32'(inst_valid), 32'd0);
        check("rd1_req", 32'(imem_req), 32'd1);
        check("rd1_addr", 32'(imem_addr), 32'(exp_addr));
        next_cyc();
        drive(1'b1, 1'b0, 32'h0);
        check("rd2_valid", 32'(inst_valid), 32'd0);
        check("rd2_addr", 32'(imem_addr), 32'(a1));
        next_cyc();
        nxt = exp_pc;
        stream(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] exp4;
        int issued, pops, sb_err, ovf;

        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        reset4 = 1'b1; ready4 = 1'b0;
        #1;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_code", inst_code, 32'd0);
        next_cyc();
        next_cyc();
        reset = 1'b0;
        startup();

        // back-pressure: head frozen, no requests once two words are owned
        hold_pc = nxt;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            check("bp_valid", 32'(inst_valid), 32'd1);
            check("bp_pc", inst_pc, hold_pc);
            check("bp_code", inst_code, code_of(hold_pc));
            check("bp_req", 32'(imem_req), 32'd0);
            next_cyc();
        end
        stream(5);

        redir(32'h40, 32'h40, 6'h10);
        redir(32'h43, 32'h40, 6'h10);
        redir(32'hFC, 32'hFC, 6'd63);

        // async reset with two entries queued
        drive(1'b0, 1'b0, 32'h0);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        check("ar_pre_valid", 32'(inst_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("ar_valid", 32'(inst_valid), 32'd0);
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_pc", inst_pc, 32'd0);
        check("ar_addr", 32'(imem_addr), 32'd0);
        next_cyc();
        reset = 1'b0;
        startup();

        // BUF_DEPTH=4 instance under random back-pressure
        inst_ready = 1'b0;
        next_cyc();
        reset4 = 1'b0;
        exp4 = '0; issued = 0; pops = 0; sb_err = 0; ovf = 0;
        for (int i = 0; i < 2000; i++) begin
            ready4 = 1'($urandom_range(0, 1));
            #1;
            if (imem_req4) issued++;
            if (inst_valid4 && ready4) begin
                if (inst_pc4 !== exp4 || inst_code4 !== code_of(exp4)) begin
                    sb_err++;
                    if (sb_err < 4)
                        $display("FAIL sweep_order: got pc=%h code=%h expected pc=%h code=%h",
                                 inst_pc4, inst_code4, exp4, code_of(exp4));
                end
                exp4 = exp4 + 32'd4;
                pops++;
            end
            if (issued - pops > 4) ovf++;
            next_cyc();
        end
        check("sweep_sb_err", 32'(sb_err), 32'd0);
        check("sweep_overflow", 32'(ovf), 32'd0);
        check("sweep_pops_ok", 32'(pops > 500), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
